// File: rtl/fnn_pkg.sv
// rtl/fnn_pkg.sv - shared types, widths and helpers for the fully connected network datapath
package fnn_pkg;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 8;

  typedef logic signed [DATA_W-1:0] data_t;

  // Accumulator wide enough that n full-scale products can never overflow.
  function automatic int acc_w(input int n, input int w = DATA_W);
    return 2 * w + $clog2(n);
  endfunction

endpackage

// File: rtl/neuron_mac_if.sv
// rtl/neuron_mac_if.sv - activation stream, weight ROM port and result stream of one neuron
interface neuron_mac_if
  import fnn_pkg::*;
#(
  parameter int DATA_W_P = DATA_W,
  parameter int ADDR_W_P = 5
) ();

  logic                       in_valid;
  logic signed [DATA_W_P-1:0] in_data;
  logic                       ren;
  logic        [ADDR_W_P-1:0] radd;
  logic signed [DATA_W_P-1:0] wout;
  logic                       out_valid;
  logic signed [DATA_W_P-1:0] out_data;
  logic                       busy;

  // Upstream layer plus weight ROM side: supplies activations and read data.
  modport master (
    output in_valid, in_data, wout,
    input  ren, radd, out_valid, out_data, busy
  );

  // Neuron side.
  modport slave (
    input  in_valid, in_data, wout,
    output ren, radd, out_valid, out_data, busy
  );

endinterface

// File: rtl/relu_sat.sv
// rtl/relu_sat.sv - rescale a full-precision sum, clamp negatives to zero and saturate positives
module relu_sat #(
  parameter int IN_W  = 34,
  parameter int OUT_W = 16,
  parameter int SHIFT = 8
) (
  input  logic signed [IN_W-1:0]  acc_i,
  output logic signed [OUT_W-1:0] res_o
);

  localparam logic signed [IN_W-1:0] MAX_POS = IN_W'((1 << (OUT_W - 1)) - 1);

  // Arithmetic shift truncates toward minus infinity, matching Q-format floor.
  logic signed [IN_W-1:0] shifted;
  assign shifted = acc_i >>> SHIFT;

  // Negative results become zero; anything above the output range clamps to max positive.
  always_comb begin
    res_o = shifted[OUT_W-1:0];
    if (shifted[IN_W-1]) begin
      res_o = '0;
    end else if (shifted > MAX_POS) begin
      res_o = MAX_POS[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// rtl/neuron_mac.sv - single-neuron multiply-accumulate with bias, ReLU and saturation
module neuron_mac
  import fnn_pkg::*;
#(
  parameter int                          numWeight    = 30,
  parameter int                          dataWidth    = DATA_W,
  parameter int                          fracBits     = FRAC_BITS,
  parameter int                          addressWidth = $clog2(numWeight),
  parameter logic signed [dataWidth-1:0] biasVal      = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  neuron_mac_if.slave  bus
);

  localparam int                      ACC_W    = acc_w(numWeight, dataWidth);
  localparam int                      PROD_W   = 2 * dataWidth;
  localparam logic [addressWidth-1:0] LAST_IDX = addressWidth'(numWeight - 1);

  logic        [addressWidth-1:0] idx_q;
  logic                           v1_q, first1_q, last1_q;
  logic signed [dataWidth-1:0]    x1_q;
  logic signed [ACC_W-1:0]        acc_q, acc_d;
  logic                           v2_q;
  logic                           out_valid_q;
  logic signed [dataWidth-1:0]    out_data_q;

  logic signed [PROD_W-1:0]       prod;
  logic signed [ACC_W-1:0]        prod_ext;
  logic signed [ACC_W-1:0]        bias_ext;
  logic signed [dataWidth-1:0]    relu_res;

  // The ROM read is issued in the same cycle the activation is offered.
  assign bus.ren  = bus.in_valid;
  assign bus.radd = bus.in_valid ? idx_q : '0;

  // Element index within the vector; wraps on the last element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (bus.in_valid) begin
      idx_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  // Stage 1: hold the activation until its weight returns from the ROM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1_q     <= '0;
      v1_q     <= 1'b0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
    end else begin
      x1_q     <= bus.in_data;
      v1_q     <= bus.in_valid;
      first1_q <= (idx_q == '0);
      last1_q  <= (idx_q == LAST_IDX);
    end
  end

  assign prod     = PROD_W'(x1_q) * PROD_W'(bus.wout);
  assign prod_ext = ACC_W'(prod);
  assign bias_ext = ACC_W'(biasVal) <<< fracBits;

  // Accumulate; the first element reloads with bias so vectors run back-to-back.
  always_comb begin
    acc_d = acc_q;
    if (v1_q) begin
      acc_d = first1_q ? (bias_ext + prod_ext) : (acc_q + prod_ext);
    end
  end

  // Stage 2: accumulator and end-of-vector flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      v2_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      v2_q  <= v1_q & last1_q;
    end
  end

  relu_sat #(
    .IN_W  (ACC_W),
    .OUT_W (dataWidth),
    .SHIFT (fracBits)
  ) u_relu_sat (
    .acc_i (acc_q),
    .res_o (relu_res)
  );

  // Stage 3: register the activated result when a vector completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= v2_q;
      if (v2_q) begin
        out_data_q <= relu_res;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = (idx_q != '0) | v1_q | v2_q;

endmodule

// File: tb/tb_neuron_mac.sv
// tb/tb_neuron_mac.sv - directed self-checking bench for neuron_mac with a registered-read ROM stub
module tb_neuron_mac;

  localparam int N = 4;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  logic        tb_valid = 1'b0;
  logic [15:0] tb_data  = '0;
  logic [15:0] rom [N];

  int n_tests = 0;
  int n_fail  = 0;
  int last_cyc = 0;

  logic [15:0] out_q0 [$];
  logic [15:0] out_q1 [$];
  int          out_c0 [$];
  logic [AW-1:0] radd_q [$];

  neuron_mac_if #(.DATA_W_P(16), .ADDR_W_P(AW)) bus0 ();
  neuron_mac_if #(.DATA_W_P(16), .ADDR_W_P(AW)) bus1 ();

  neuron_mac #(.numWeight(N), .biasVal(16'sh0000)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  neuron_mac #(.numWeight(N), .biasVal(16'sh0180)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  assign bus0.in_valid = tb_valid;
  assign bus0.in_data  = tb_data;
  assign bus1.in_valid = tb_valid;
  assign bus1.in_data  = tb_data;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM stubs: one-cycle registered read.
  always @(posedge clk) begin
    if (bus0.ren) bus0.wout <= rom[bus0.radd];
    if (bus1.ren) bus1.wout <= rom[bus1.radd];
  end

  // Monitor on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus0.out_valid) begin
      out_q0.push_back(bus0.out_data);
      out_c0.push_back(cyc);
    end
    if (bus1.out_valid) out_q1.push_back(bus1.out_data);
    if (bus0.ren) radd_q.push_back(bus0.radd);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] at16(input logic [15:0] q [$], input int i);
    return (q.size() > i) ? {16'h0, q[i]} : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] at_int(input int q [$], input int i);
    return (q.size() > i) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic drive(input logic v, input logic [15:0] d);
    @(posedge clk);
    #1;
    tb_valid = v;
    tb_data  = d;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 16'h0);
  endtask

  task automatic send_vec(input logic [15:0] e0, input logic [15:0] e1,
                          input logic [15:0] e2, input logic [15:0] e3, input int maxb);
    logic [15:0] v [N];
    v[0] = e0; v[1] = e1; v[2] = e2; v[3] = e3;
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, maxb)) drive(1'b0, 16'h0);
      drive(1'b1, v[i]);
    end
    last_cyc = cyc;
  endtask

  task automatic clear_q();
    out_q0.delete();
    out_q1.delete();
    out_c0.delete();
    radd_q.delete();
  endtask

  task automatic set_rom(input logic [15:0] w0, input logic [15:0] w1,
                         input logic [15:0] w2, input logic [15:0] w3);
    rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
  endtask

  int c0;

  initial begin
    set_rom(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'h0, bus0.out_valid}, 32'h0);
    check("rst_out_data",  {16'h0, bus0.out_data}, 32'h0);
    check("rst_busy",      {31'h0, bus0.busy}, 32'h0);
    check("rst_ren",       {31'h0, bus0.ren}, 32'h0);
    check("rst_radd",      {30'h0, bus0.radd}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Basic sum: 1+2+3+4 = 10.0
    clear_q();
    send_vec(16'h0100, 16'h0200, 16'h0300, 16'h0400, 0);
    c0 = last_cyc;
    idle(6);
    check("basic_count", out_q0.size(), 32'd1);
    check("basic_data",  at16(out_q0, 0), 32'h0A00);
    check("basic_bias",  at16(out_q1, 0), 32'h0B80);
    check("basic_lat",   at_int(out_c0, 0), c0 + 3);
    for (int i = 0; i < N; i++)
      check($sformatf("basic_radd%0d", i), (radd_q.size() > i) ? {30'h0, radd_q[i]} : 32'hDEAD_BEEF, i);

    // ReLU floor: weights -1.0
    set_rom(16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00);
    clear_q();
    send_vec(16'h0100, 16'h0200, 16'h0300, 16'h0400, 0);
    idle(6);
    check("floor_data", at16(out_q0, 0), 32'h0000);
    check("floor_bias", at16(out_q1, 0), 32'h0000);

    // Saturation
    set_rom(16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00);
    clear_q();
    send_vec(16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 0);
    idle(6);
    check("sat_data", at16(out_q0, 0), 32'h7FFF);
    check("sat_bias", at16(out_q1, 0), 32'h7FFF);

    // Bias only
    set_rom(16'h0100, 16'h0200, 16'hFF00, 16'h0080);
    clear_q();
    send_vec(16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);
    idle(6);
    check("bias_zero", at16(out_q0, 0), 32'h0000);
    check("bias_val",  at16(out_q1, 0), 32'h0180);

    // Back-to-back with weights {1.0, 2.0, -1.0, 0.5}: A = 4.0, B = 8.0
    clear_q();
    send_vec(16'h0100, 16'h0200, 16'h0300, 16'h0400, 0);
    c0 = last_cyc;
    send_vec(16'h0300, 16'h0080, 16'h0000, 16'h0800, 0);
    idle(6);
    check("b2b_count", out_q0.size(), 32'd2);
    check("b2b_a",     at16(out_q0, 0), 32'h0400);
    check("b2b_b",     at16(out_q0, 1), 32'h0800);
    check("b2b_a_bias", at16(out_q1, 0), 32'h0580);
    check("b2b_b_bias", at16(out_q1, 1), 32'h0980);
    check("b2b_lat",   at_int(out_c0, 0), c0 + 3);
    check("b2b_gap",   at_int(out_c0, 1) - at_int(out_c0, 0), 32'd4);

    // Same vectors with random bubbles
    clear_q();
    send_vec(16'h0100, 16'h0200, 16'h0300, 16'h0400, 3);
    send_vec(16'h0300, 16'h0080, 16'h0000, 16'h0800, 3);
    idle(6);
    check("bub_count",  out_q0.size(), 32'd2);
    check("bub_a",      at16(out_q0, 0), 32'h0400);
    check("bub_b",      at16(out_q0, 1), 32'h0800);
    check("bub_a_bias", at16(out_q1, 0), 32'h0580);
    check("bub_b_bias", at16(out_q1, 1), 32'h0980);

    // Reset after two elements
    drive(1'b1, 16'h0400);
    drive(1'b1, 16'h0400);
    @(posedge clk); #1;
    check("mid_busy", {31'h0, bus0.busy}, 32'h1);
    rst_n = 1'b0;
    tb_valid = 1'b0;
    tb_data = 16'h0;
    #1;
    check("mid_rst_out_valid", {31'h0, bus0.out_valid}, 32'h0);
    check("mid_rst_out_data",  {16'h0, bus0.out_data}, 32'h0);
    check("mid_rst_busy",      {31'h0, bus0.busy}, 32'h0);
    check("mid_rst_ren",       {31'h0, bus0.ren}, 32'h0);
    check("mid_rst_radd",      {30'h0, bus0.radd}, 32'h0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    clear_q();
    // 1.0*1.0 + 3*0.5 LSB -> 0x0101 truncated; with bias 0x0281
    send_vec(16'h0100, 16'h0000, 16'h0000, 16'h0003, 0);
    idle(6);
    check("post_count", out_q0.size(), 32'd1);
    check("post_data",  at16(out_q0, 0), 32'h0101);
    check("post_bias",  at16(out_q1, 0), 32'h0281);
    for (int i = 0; i < N; i++)
      check($sformatf("post_radd%0d", i), (radd_q.size() > i) ? {30'h0, radd_q[i]} : 32'hDEAD_BEEF, i);
    check("post_busy", {31'h0, bus0.busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
